pipe_if_fetch: RTL
==================

# pipe_if_fetch

Instruction-fetch stage and IF/ID pipeline register of the five-stage pipelined CPU. Holds the PC, issues one-outstanding requests to instruction memory over a req/ack handshake, and presents the fetched word with its PC+4 to the decode stage. It obeys the decode stage's load-use stall (`wpcir`) and its redirect (`pcsource` plus targets). Wrong-path words are replaced by bubbles.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wpcir`  in  1  1 = decode may advance; 0 = hold PC and IF/ID (load-use stall).
- `pcsource`  in  2  00 sequential, 01 branch (`bpc`), 10 register jump (`rpc`), 11 jump (`jpc`); ignored while `wpcir`=0.
- `bpc`, `rpc`, `jpc`  in  32 each  redirect targets from decode.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ack`  in  1  single-cycle acknowledge; may be asserted in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word, valid only with `imem_ack`.
- `dpc4`  out  32  IF/ID PC+4 of the instruction in decode.
- `dinst`  out  32  IF/ID instruction; 32'h0 (NOP) when bubble.
- `dvalid`  out  1  IF/ID holds a real instruction.
- `pc`  out  32  current fetch PC (debug).

## Operation
- `redir` = `wpcir` & (`pcsource`≠00). `target` = `bpc`/`rpc`/`jpc` selected by `pcsource`.
- Bubble load: `dinst`←0, `dvalid`←0, `dpc4` unchanged.
- When `wpcir`=0, IF/ID always holds.
- **REQ** (`imem_req`=1, `imem_addr`=`pc`):
  - ack & `wpcir` & ~`redir`: IF/ID←{`pc`+4, `imem_rdata`, 1}; `pc`←`pc`+4; stay REQ.
  - ack & `redir`: bubble; `pc`←`target`; stay REQ. The word is discarded.
  - ack & ~`wpcir`: `buf`←`imem_rdata`; go to FULL.
  - ~ack & `redir`: bubble; `tgt`←`target`; go to DROP. `pc` stays so the address remains stable.
  - ~ack & `wpcir`: bubble; stay REQ.
- **FULL** (`imem_req`=0):
  - `wpcir` & ~`redir`: IF/ID←{`pc`+4, `buf`, 1}; `pc`←`pc`+4; go to REQ.
  - `redir`: bubble; `pc`←`target`; `buf` is discarded; go to REQ.
  - ~`wpcir`: stay FULL.
- **DROP** (`imem_req`=1, `imem_addr`=old `pc`):
  - Load a bubble whenever `wpcir`=1; `pcsource` is ignored.
  - On ack: discard the word; `pc`←`tgt`; go to REQ.
- Arithmetic: `pc`+4 is modulo 2^32 (0xFFFFFFFC wraps to 0). No alignment check on targets.

## Timing
- Reset values: state REQ, `pc`=`RESET_PC`, `dpc4`=0, `dinst`=0, `dvalid`=0, `buf`=0, `tgt`=0. `imem_req`=1 and `imem_addr`=`RESET_PC` while in reset and immediately after.
- `imem_req` and `imem_addr` are decoded from state and `pc` only. There is no combinational path from `imem_ack`, `wpcir` or `pcsource`.
- `imem_addr` is stable from request assertion until its ack.
- Zero-wait memory sustains 1 instruction/cycle. With latency L, a new instruction enters IF/ID every L+1 cycles.
- Taken redirect costs 1 bubble with zero-wait memory. A redirect during a wait state costs the remaining wait, plus one full fetch at the target.
- Reset asserted mid-operation (any state) takes effect immediately. An ack arriving in the first cycle after release is accepted as the word for `RESET_PC`; the memory side must itself be reset.

## Structure
- Shared package `pipe_pkg`:
  - state enum {REQ, FULL, DROP};
  - `pcsource` encodings (PCS_SEQ, PCS_BR, PCS_JR, PCS_J);
  - NOP constant 32'h0.
- Sub-module `pipe_npc_mux`: combinational 4:1 target select from `pcsource`, `pc`+4, `bpc`, `rpc`, `jpc`. The FSM, PC, `buf`, `tgt` and IF/ID registers live in `pipe_if_fetch`.

## Test plan
- Reset, zero-wait ROM, `wpcir`=1: `imem_addr` goes 0,4,8; `dinst` follows ROM[0],[1],[2] one cycle later; `dpc4`=4,8,12; `dvalid`=1.
- Stall: `wpcir`=0 for 2 cycles coincident with ack of addr 8:
  - FULL entered, `imem_req`=0, IF/ID held;
  - on release, `dinst`=ROM[2] with no refetch of 8, then `imem_addr`=12.
- Branch: `pcsource`=01, `bpc`=0x40 with ack at 0x10:
  - next IF/ID is a bubble (`dinst`=0, `dvalid`=0);
  - `imem_addr`=0x40 next cycle.
- Memory latency 3, jump `pcsource`=11, `jpc`=0x100 one cycle into the wait:
  - `imem_addr` stays at the old address until ack, and that word is dropped;
  - then `imem_addr`=0x100, with `dvalid`=0 throughout.
- Async reset asserted in DROP: same-instant `pc`=`RESET_PC`, `dvalid`=0, `imem_req`=1; the pending jump is lost.
- `RESET_PC`=0xFFFFFFFC: first fetch at 0xFFFFFFFC gives `dpc4`=0; second `imem_addr`=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline fetch stage: fetch FSM states,
// pcsource encodings and the NOP word used for bubbles.
package pipe_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        FULL = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [1:0]  PCS_SEQ = 2'b00;
    localparam logic [1:0]  PCS_BR  = 2'b01;
    localparam logic [1:0]  PCS_JR  = 2'b10;
    localparam logic [1:0]  PCS_J   = 2'b11;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_npc_mux.sv
// Next-PC select: sequential PC+4 or one of the three redirect targets
// supplied by decode.
module pipe_npc_mux
    import pipe_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic [31:0] npc
);

    // 4:1 target select keyed on the decode stage's pcsource
    always_comb begin
        npc = pc4;
        unique case (pcsource)
            PCS_SEQ: npc = pc4;
            PCS_BR:  npc = bpc;
            PCS_JR:  npc = rpc;
            PCS_J:   npc = jpc;
            default: npc = pc4;
        endcase
    end

endmodule

// File: rtl/pipe_if_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register. One outstanding
// imem request at a time; words fetched while decode is stalled are parked
// in fetch_buf_p0, and requests in flight when a redirect arrives are
// drained (DROP) so the address stays stable until the memory acks.
module pipe_if_fetch
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dpc4,
    output logic [31:0] dinst,
    output logic        dvalid,
    output logic [31:0] pc
);

    fetch_state_e state_q, state_n;

    logic [31:0] pc_p0, pc_n;
    logic [31:0] fetch_buf_p0, fetch_buf_n;
    logic [31:0] tgt_p0, tgt_n;

    logic [31:0] dpc4_p1, dpc4_n;
    logic [31:0] dinst_p1, dinst_n;
    logic        vld_p1, vld_n;

    logic [31:0] pc4;
    logic [31:0] npc;
    logic        redir;

    assign pc4   = pc_p0 + 32'd4;
    assign redir = wpcir & (pcsource != PCS_SEQ);

    pipe_npc_mux u_npc_mux (
        .pcsource (pcsource),
        .pc4      (pc4),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .npc      (npc)
    );

    // Request side depends only on registered state, never on ack or decode inputs
    assign imem_req  = (state_q != FULL);
    assign imem_addr = pc_p0;
    assign pc        = pc_p0;

    assign dpc4   = dpc4_p1;
    assign dinst  = dinst_p1;
    assign dvalid = vld_p1;

    // Fetch FSM next-state, PC update and IF/ID load decisions
    always_comb begin
        state_n     = state_q;
        pc_n        = pc_p0;
        fetch_buf_n = fetch_buf_p0;
        tgt_n       = tgt_p0;
        dpc4_n      = dpc4_p1;
        dinst_n     = dinst_p1;
        vld_n       = vld_p1;

        unique case (state_q)
            REQ: begin
                if (imem_ack) begin
                    if (wpcir) begin
                        // npc is pc+4 when not redirecting, the target otherwise
                        pc_n = npc;
                        if (redir) begin
                            dinst_n = NOP;
                            vld_n   = 1'b0;
                        end else begin
                            dpc4_n  = pc4;
                            dinst_n = imem_rdata;
                            vld_n   = 1'b1;
                        end
                    end else begin
                        fetch_buf_n = imem_rdata;
                        state_n     = FULL;
                    end
                end else if (redir) begin
                    // keep pc (and thus imem_addr) stable until the ack drains
                    dinst_n = NOP;
                    vld_n   = 1'b0;
                    tgt_n   = npc;
                    state_n = DROP;
                end else if (wpcir) begin
                    dinst_n = NOP;
                    vld_n   = 1'b0;
                end
            end

            FULL: begin
                if (wpcir) begin
                    pc_n    = npc;
                    state_n = REQ;
                    if (redir) begin
                        dinst_n = NOP;
                        vld_n   = 1'b0;
                    end else begin
                        dpc4_n  = pc4;
                        dinst_n = fetch_buf_p0;
                        vld_n   = 1'b1;
                    end
                end
            end

            DROP: begin
                // redirects are ignored here; the first one already won
                if (wpcir) begin
                    dinst_n = NOP;
                    vld_n   = 1'b0;
                end
                if (imem_ack) begin
                    pc_n    = tgt_p0;
                    state_n = REQ;
                end
            end

            default: begin
                state_n = REQ;
            end
        endcase
    end

    // State, PC and IF/ID registers; reset takes effect immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= REQ;
            pc_p0        <= RESET_PC;
            fetch_buf_p0 <= 32'h0;
            tgt_p0       <= 32'h0;
            dpc4_p1      <= 32'h0;
            dinst_p1     <= NOP;
            vld_p1       <= 1'b0;
        end else begin
            state_q      <= state_n;
            pc_p0        <= pc_n;
            fetch_buf_p0 <= fetch_buf_n;
            tgt_p0       <= tgt_n;
            dpc4_p1      <= dpc4_n;
            dinst_p1     <= dinst_n;
            vld_p1       <= vld_n;
        end
    end

endmodule
